uart_cmd_deframer: RTL and testbench

//  Fabric-side consumer of the MSS UART transmit line (MMUART_0_TXD_M2F). Oversampling 8N1

---
 rtl/uart_cmd_deframer.sv | 231 +++++++++++++++++++++++
 tb/tb_uart_cmd_deframer.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_cmd_deframer.sv
// Oversampling 8N1 receiver and A5|OP|LEN|PAYLOAD|CSUM frame parser.
// Validated frames are double-buffered and offered to the consumer through a valid/ready handshake.
module uart_cmd_deframer #(
    parameter int  BAUD_DIV     = 27,
    parameter int  MAX_LEN      = 64,
    parameter int  TIMEOUT_BITS = 40,
    localparam int AW           = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1,
    localparam int LW           = $clog2(MAX_LEN + 1)
) (
    input  logic          CLK_BASE,
    input  logic          RESET,
    input  logic          RXD,
    output logic          CMD_VALID,
    input  logic          CMD_READY,
    output logic [7:0]    CMD_OP,
    output logic [LW-1:0] CMD_LEN,
    input  logic [AW-1:0] RD_ADDR,
    output logic [7:0]    RD_DATA,
    output logic          ERR_STB,
    output logic [2:0]    ERR_CODE,
    output logic [7:0]    ERR_CNT
);

    localparam int            DW        = $clog2(BAUD_DIV + 1);
    localparam logic [DW-1:0] DIV_LAST  = DW'(BAUD_DIV - 1);
    localparam int            TMO_TICKS = TIMEOUT_BITS * 16;
    localparam int            TW        = $clog2(TMO_TICKS + 1);
    localparam logic [TW-1:0] TMO_LAST  = TW'(TMO_TICKS - 1);
    localparam logic [7:0]    MAX_LEN_B = 8'(MAX_LEN);
    localparam logic [7:0]    SOF       = 8'hA5;

    localparam logic [2:0] E_FRAME = 3'd1;
    localparam logic [2:0] E_CSUM  = 3'd2;
    localparam logic [2:0] E_OVER  = 3'd3;
    localparam logic [2:0] E_TMO   = 3'd4;
    localparam logic [2:0] E_BUSY  = 3'd5;

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_st_e;
    typedef enum logic [2:0] {P_HUNT, P_OP, P_LEN, P_DATA, P_CSUM} p_st_e;

    // ---------------- synchroniser and 1/16-bit tick ----------------
    logic          rxd_s1_q, rxd_s2_q, rxd_prev_q;
    logic [DW-1:0] div_q;
    logic          tick;

    assign tick = (div_q == DIV_LAST);

    always_ff @(posedge CLK_BASE or posedge RESET) begin
        if (RESET) begin
            rxd_s1_q   <= 1'b1;
            rxd_s2_q   <= 1'b1;
            rxd_prev_q <= 1'b1;
            div_q      <= '0;
        end else begin
            rxd_s1_q   <= RXD;
            rxd_s2_q   <= rxd_s1_q;
            rxd_prev_q <= rxd_s2_q;
            div_q      <= tick ? '0 : div_q + DW'(1);
        end
    end

    // ---------------- byte receiver ----------------
    rx_st_e     rx_st_q;
    logic [3:0] tcnt_q;
    logic [2:0] bcnt_q;
    logic [7:0] shreg_q;
    logic       byte_stb_q, ferr_q;

    always_ff @(posedge CLK_BASE or posedge RESET) begin
        if (RESET) begin
            rx_st_q    <= RX_IDLE;
            tcnt_q     <= '0;
            bcnt_q     <= '0;
            shreg_q    <= '0;
            byte_stb_q <= 1'b0;
            ferr_q     <= 1'b0;
        end else begin
            byte_stb_q <= 1'b0;
            ferr_q     <= 1'b0;
            case (rx_st_q)
                RX_IDLE: begin
                    tcnt_q <= '0;
                    if (rxd_prev_q && !rxd_s2_q) rx_st_q <= RX_START;
                end
                RX_START: if (tick) begin
                    if (tcnt_q == 4'd7) begin
                        tcnt_q  <= '0;
                        bcnt_q  <= '0;
                        rx_st_q <= rxd_s2_q ? RX_IDLE : RX_DATA;
                    end else begin
                        tcnt_q <= tcnt_q + 4'd1;
                    end
                end
                // tcnt wraps 15->0, so each sample lands 16 ticks after the previous one
                RX_DATA: if (tick) begin
                    tcnt_q <= tcnt_q + 4'd1;
                    if (tcnt_q == 4'd15) begin
                        shreg_q <= {rxd_s2_q, shreg_q[7:1]};
                        bcnt_q  <= bcnt_q + 3'd1;
                        if (bcnt_q == 3'd7) rx_st_q <= RX_STOP;
                    end
                end
                RX_STOP: if (tick) begin
                    tcnt_q <= tcnt_q + 4'd1;
                    if (tcnt_q == 4'd15) begin
                        byte_stb_q <= rxd_s2_q;
                        ferr_q     <= !rxd_s2_q;
                        rx_st_q    <= RX_IDLE;
                    end
                end
                default: rx_st_q <= RX_IDLE;
            endcase
        end
    end

    // ---------------- frame parser ----------------
    p_st_e         p_st_q;
    logic [7:0]    op_sh_q, csum_q;
    logic [LW-1:0] len_sh_q, idx_q;
    logic [TW-1:0] tmo_q;
    logic          sel_q;
    logic          cmd_valid_q;
    logic [7:0]    cmd_op_q;
    logic [LW-1:0] cmd_len_q;
    logic          err_stb_q;
    logic [2:0]    err_code_q;
    logic [7:0]    err_cnt_q, rd_data_q;
    logic [7:0]    buf_q [2][MAX_LEN];

    logic       tmo_hit, byte_ok, csum_ok, accept, buf_we, err_d;
    logic [2:0] code_d;

    // The timeout only counts ticks while the line is idle, so a byte in flight never expires.
    assign tmo_hit = (p_st_q != P_HUNT) && (rx_st_q == RX_IDLE) && tick && (tmo_q == TMO_LAST);
    assign byte_ok = byte_stb_q && !tmo_hit;
    assign csum_ok = (shreg_q == csum_q);
    assign accept  = byte_ok && (p_st_q == P_CSUM) && csum_ok && (!cmd_valid_q || CMD_READY);
    assign buf_we  = byte_ok && (p_st_q == P_DATA);

    always_comb begin
        err_d  = 1'b1;
        code_d = E_FRAME;
        if (tmo_hit)                                               code_d = E_TMO;
        else if (ferr_q)                                           code_d = E_FRAME;
        else if (byte_ok && p_st_q == P_LEN && shreg_q > MAX_LEN_B) code_d = E_OVER;
        else if (byte_ok && p_st_q == P_CSUM && !csum_ok)          code_d = E_CSUM;
        else if (byte_ok && p_st_q == P_CSUM && !accept)           code_d = E_BUSY;
        else                                                       err_d  = 1'b0;
    end

    // Incoming payload always goes to the bank not currently presented.
    always_ff @(posedge CLK_BASE) begin
        if (buf_we) buf_q[~sel_q][idx_q[AW-1:0]] <= shreg_q;
    end

    always_ff @(posedge CLK_BASE or posedge RESET) begin
        if (RESET) begin
            p_st_q      <= P_HUNT;
            op_sh_q     <= '0;
            csum_q      <= '0;
            len_sh_q    <= '0;
            idx_q       <= '0;
            tmo_q       <= '0;
            sel_q       <= 1'b0;
            cmd_valid_q <= 1'b0;
            cmd_op_q    <= '0;
            cmd_len_q   <= '0;
            err_stb_q   <= 1'b0;
            err_code_q  <= '0;
            err_cnt_q   <= '0;
            rd_data_q   <= '0;
        end else begin
            rd_data_q <= buf_q[sel_q][RD_ADDR];

            err_stb_q <= err_d;
            if (err_d) begin
                err_code_q <= code_d;
                if (err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'd1;
            end

            if (accept) begin
                cmd_valid_q <= 1'b1;
                cmd_op_q    <= op_sh_q;
                cmd_len_q   <= len_sh_q;
                sel_q       <= ~sel_q;
            end else if (CMD_READY) begin
                cmd_valid_q <= 1'b0;
            end

            if (tmo_hit || ferr_q) begin
                p_st_q <= P_HUNT;
                tmo_q  <= '0;
            end else if (byte_ok) begin
                tmo_q <= '0;
                case (p_st_q)
                    P_HUNT: if (shreg_q == SOF) p_st_q <= P_OP;
                    P_OP: begin
                        op_sh_q <= shreg_q;
                        csum_q  <= shreg_q;
                        p_st_q  <= P_LEN;
                    end
                    P_LEN: begin
                        csum_q   <= csum_q ^ shreg_q;
                        len_sh_q <= shreg_q[LW-1:0];
                        idx_q    <= '0;
                        if (shreg_q > MAX_LEN_B)  p_st_q <= P_HUNT;
                        else if (shreg_q == 8'd0) p_st_q <= P_CSUM;
                        else                      p_st_q <= P_DATA;
                    end
                    P_DATA: begin
                        csum_q <= csum_q ^ shreg_q;
                        idx_q  <= idx_q + LW'(1);
                        if (idx_q + LW'(1) == len_sh_q) p_st_q <= P_CSUM;
                    end
                    default: p_st_q <= P_HUNT;
                endcase
            end else if (p_st_q != P_HUNT && rx_st_q == RX_IDLE && tick) begin
                tmo_q <= tmo_q + TW'(1);
            end
        end
    end

    assign CMD_VALID = cmd_valid_q;
    assign CMD_OP    = cmd_op_q;
    assign CMD_LEN   = cmd_len_q;
    assign RD_DATA   = rd_data_q;
    assign ERR_STB   = err_stb_q;
    assign ERR_CODE  = err_code_q;
    assign ERR_CNT   = err_cnt_q;

endmodule

// File: tb/tb_uart_cmd_deframer.sv
// Directed bench for uart_cmd_deframer: serial frames driven bit by bit, outputs checked
// against hand-computed values; a second fast-baud instance exercises ERR_CNT saturation.
module tb_uart_cmd_deframer;

    localparam int BAUD_DIV     = 2;
    localparam int MAX_LEN      = 8;
    localparam int TIMEOUT_BITS = 4;
    localparam int BIT_CLKS     = 16 * BAUD_DIV;

    logic       clk = 1'b0, rst = 1'b1, rxd = 1'b1, cmd_ready = 1'b0;
    logic [2:0] rd_addr = '0;
    logic       cmd_valid, err_stb;
    logic [7:0] cmd_op, rd_data, err_cnt;
    logic [3:0] cmd_len;
    logic [2:0] err_code;

    logic       s_rxd = 1'b1, s_ready = 1'b0;
    logic [2:0] s_addr = '0;
    logic       s_valid, s_stb;
    logic [7:0] s_op, s_rd, s_cnt;
    logic [3:0] s_len;
    logic [2:0] s_code;

    always #5 clk = ~clk;

    uart_cmd_deframer #(.BAUD_DIV(BAUD_DIV), .MAX_LEN(MAX_LEN), .TIMEOUT_BITS(TIMEOUT_BITS)) dut (
        .CLK_BASE(clk), .RESET(rst), .RXD(rxd),
        .CMD_VALID(cmd_valid), .CMD_READY(cmd_ready), .CMD_OP(cmd_op), .CMD_LEN(cmd_len),
        .RD_ADDR(rd_addr), .RD_DATA(rd_data),
        .ERR_STB(err_stb), .ERR_CODE(err_code), .ERR_CNT(err_cnt)
    );

    uart_cmd_deframer #(.BAUD_DIV(1), .MAX_LEN(MAX_LEN), .TIMEOUT_BITS(TIMEOUT_BITS)) dut_sat (
        .CLK_BASE(clk), .RESET(rst), .RXD(s_rxd),
        .CMD_VALID(s_valid), .CMD_READY(s_ready), .CMD_OP(s_op), .CMD_LEN(s_len),
        .RD_ADDR(s_addr), .RD_DATA(s_rd),
        .ERR_STB(s_stb), .ERR_CODE(s_code), .ERR_CNT(s_cnt)
    );

    int         errors = 0, checks = 0;
    int         n_stb = 0, base = 0;
    logic [2:0] last_code = '0;
    logic [7:0] frm [$];

    always @(negedge clk) begin
        if (err_stb) begin
            n_stb++;
            last_code = err_code;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        rxd = 1'b0;
        repeat (BIT_CLKS) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            repeat (BIT_CLKS) @(negedge clk);
        end
        rxd = stop;
        repeat (BIT_CLKS) @(negedge clk);
        rxd = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic send_frm();
        foreach (frm[i]) send_byte(frm[i], 1'b1);
        repeat (2) @(negedge clk);
    endtask

    task automatic release_frame();
        cmd_ready = 1'b1;
        @(negedge clk);
        cmd_ready = 1'b0;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_valid", cmd_valid, 0);
        check("rst_op", cmd_op, 0);
        check("rst_len", cmd_len, 0);
        check("rst_rd", rd_data, 0);
        check("rst_stb", err_stb, 0);
        check("rst_code", err_code, 0);
        check("rst_cnt", err_cnt, 0);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // good 2-byte frame, csum = 10^02^11^22 = 21
        frm = '{8'hA5, 8'h10, 8'h02, 8'h11, 8'h22, 8'h21};
        send_frm();
        check("t1_valid", cmd_valid, 1);
        check("t1_op", cmd_op, 8'h10);
        check("t1_len", cmd_len, 2);
        rd_addr = 3'd0;
        @(negedge clk);
        check("t1_rd0", rd_data, 8'h11);
        rd_addr = 3'd1;
        @(negedge clk);
        check("t1_rd1", rd_data, 8'h22);
        check("t1_noerr", n_stb, 0);
        release_frame();
        check("t1_release", cmd_valid, 0);

        // bad checksum (expected 44)
        base = n_stb;
        frm = '{8'hA5, 8'h10, 8'h01, 8'h55, 8'h00};
        send_frm();
        check("t2_nstb", n_stb - base, 1);
        check("t2_code", last_code, 2);
        check("t2_cnt", err_cnt, 1);
        check("t2_valid", cmd_valid, 0);

        // stop bit 0 inside a frame, then a zero-length frame
        frm = '{8'hA5, 8'h20};
        send_frm();
        send_byte(8'h33, 1'b0);
        repeat (2) @(negedge clk);
        check("t3_code", last_code, 1);
        check("t3_cnt", err_cnt, 2);
        check("t3_valid0", cmd_valid, 0);
        frm = '{8'hA5, 8'h20, 8'h00, 8'h20};
        send_frm();
        check("t3_valid", cmd_valid, 1);
        check("t3_op", cmd_op, 8'h20);
        check("t3_len", cmd_len, 0);
        check("t3_cnt2", err_cnt, 2);
        release_frame();

        // two frames with READY low: second one is lost as busy
        frm = '{8'hA5, 8'h40, 8'h01, 8'hAA, 8'hEB};
        send_frm();
        check("t4_valid", cmd_valid, 1);
        check("t4_op", cmd_op, 8'h40);
        base = n_stb;
        frm = '{8'hA5, 8'h50, 8'h01, 8'hBB, 8'hEA};
        send_frm();
        check("t4_nstb", n_stb - base, 1);
        check("t4_code", last_code, 5);
        check("t4_cnt", err_cnt, 3);
        check("t4_op_hold", cmd_op, 8'h40);
        check("t4_len_hold", cmd_len, 1);
        rd_addr = 3'd0;
        @(negedge clk);
        check("t4_rd_hold", rd_data, 8'hAA);
        release_frame();
        check("t4_release", cmd_valid, 0);
        check("t4_op_after", cmd_op, 8'h40);

        // maximum-length payload, csum = 60^08^(01^..^08) = 60
        frm = '{8'hA5, 8'h60, 8'h08, 8'h01, 8'h02, 8'h03, 8'h04,
                8'h05, 8'h06, 8'h07, 8'h08, 8'h60};
        send_frm();
        check("tm_valid", cmd_valid, 1);
        check("tm_op", cmd_op, 8'h60);
        check("tm_len", cmd_len, 8);
        check("tm_cnt", err_cnt, 3);
        rd_addr = 3'd7;
        @(negedge clk);
        check("tm_rd7", rd_data, 8'h08);

        // oversize then inter-byte timeout; pending frame stays untouched
        frm = '{8'hA5, 8'h30, 8'h09};
        send_frm();
        check("t5_over", last_code, 3);
        check("t5_cnt", err_cnt, 4);
        base = n_stb;
        frm = '{8'hA5, 8'h30};
        send_frm();
        check("t5_notmo_yet", n_stb - base, 0);
        repeat (200) @(negedge clk);
        check("t5_tmo_nstb", n_stb - base, 1);
        check("t5_tmo", last_code, 4);
        check("t5_cnt2", err_cnt, 5);
        check("t5_pending_op", cmd_op, 8'h60);
        check("t5_pending_vld", cmd_valid, 1);

        // reset in the middle of a payload
        frm = '{8'hA5, 8'h70, 8'h03, 8'h11};
        send_frm();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("t6_valid", cmd_valid, 0);
        check("t6_op", cmd_op, 0);
        check("t6_len", cmd_len, 0);
        check("t6_rd", rd_data, 0);
        check("t6_stb", err_stb, 0);
        check("t6_cnt", err_cnt, 0);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // 4-tick low glitch in idle is a false start
        base = n_stb;
        rxd = 1'b0;
        repeat (4 * BAUD_DIV) @(negedge clk);
        rxd = 1'b1;
        repeat (400) @(negedge clk);
        check("t6_glitch_nstb", n_stb - base, 0);
        check("t6_glitch_cnt", err_cnt, 0);
        check("t6_glitch_vld", cmd_valid, 0);
        frm = '{8'hA5, 8'h20, 8'h00, 8'h20};
        send_frm();
        check("t6_after_vld", cmd_valid, 1);
        check("t6_after_op", cmd_op, 8'h20);

        // ERR_CNT saturation: 300 framing errors on the fast instance
        for (int i = 0; i < 10; i++) begin
            s_rxd = 1'b0;
            repeat (170) @(negedge clk);
            s_rxd = 1'b1;
            repeat (6) @(negedge clk);
        end
        check("sat_cnt10", s_cnt, 10);
        check("sat_code", s_code, 1);
        for (int i = 0; i < 290; i++) begin
            s_rxd = 1'b0;
            repeat (170) @(negedge clk);
            s_rxd = 1'b1;
            repeat (6) @(negedge clk);
        end
        check("sat_cnt", s_cnt, 255);
        check("sat_valid", s_valid, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
